// File: rtl/tone_generator_multi.sv
// ============================================================================
// Module  : tone_generator_multi
// Brief   : Oscillator voice core: phase accumulator, tri/saw/pulse/noise
//           waveforms AND-combined, with hard sync and XOR ring modulation.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tone_generator_multi #(
  parameter int ACCUMULATOR_BITS = 24,
  parameter int FREQ_BITS        = 16,
  parameter int PULSEWIDTH_BITS  = 12,
  parameter int OUTPUT_BITS      = 12
) (
  input  logic                       main_clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic [FREQ_BITS-1:0]       tone_freq,
  input  logic [PULSEWIDTH_BITS-1:0] pulse_width,
  input  logic                       en_saw,
  input  logic                       en_tri,
  input  logic                       en_pulse,
  input  logic                       en_noise,
  input  logic                       test,
  input  logic                       en_sync,
  input  logic                       sync_source,
  input  logic                       en_ringmod,
  input  logic                       ringmod_source,
  output logic [OUTPUT_BITS-1:0]     dout,
  output logic                       dout_valid,
  output logic                       msb_out
);

  localparam logic [22:0] c_LFSR_SEED = 23'h7FFFF8;

  logic [ACCUMULATOR_BITS-1:0] r_acc;
  logic                        r_sync_prev;
  logic [22:0]                 r_lfsr;
  logic                        r_noise_clk_prev;
  logic [OUTPUT_BITS-1:0]      r_dout;
  logic                        r_dout_valid;
  logic                        r_msb;

  logic [ACCUMULATOR_BITS-1:0] w_acc_next;
  logic [22:0]                 w_lfsr_next;
  logic                        w_sync_edge;
  logic                        w_noise_clk;
  logic                        w_lfsr_step;
  logic                        w_invert;
  logic [OUTPUT_BITS-1:0]      w_saw;
  logic [OUTPUT_BITS-1:0]      w_triangle;
  logic [OUTPUT_BITS-1:0]      w_pulse;
  logic [OUTPUT_BITS-1:0]      w_noise;
  logic [OUTPUT_BITS-1:0]      w_mix;
  logic                        w_any;

  // Sync edge is judged between consecutive ticks, not consecutive clocks.
  assign w_sync_edge = en_sync & sync_source & ~r_sync_prev;

  always_comb begin
    w_acc_next = r_acc + ACCUMULATOR_BITS'(tone_freq);
    if (test || w_sync_edge) begin
      w_acc_next = '0;
    end
  end

  assign w_noise_clk = w_acc_next[ACCUMULATOR_BITS-5];
  assign w_lfsr_step = w_noise_clk & ~r_noise_clk_prev;

  always_comb begin
    w_lfsr_next = r_lfsr;
    if (test) begin
      w_lfsr_next = c_LFSR_SEED;
    end else if (w_lfsr_step) begin
      if (r_lfsr == 23'd0) begin
        w_lfsr_next = c_LFSR_SEED;
      end else begin
        w_lfsr_next = {r_lfsr[21:0], r_lfsr[22] ^ r_lfsr[17]};
      end
    end
  end

  // Waveforms are derived from the post-update accumulator and LFSR.
  assign w_invert   = en_ringmod ? (w_acc_next[ACCUMULATOR_BITS-1] ^ ringmod_source)
                                 : w_acc_next[ACCUMULATOR_BITS-1];
  assign w_saw      = w_acc_next[ACCUMULATOR_BITS-1 -: OUTPUT_BITS];
  assign w_triangle = w_invert ? ~w_acc_next[ACCUMULATOR_BITS-2 -: OUTPUT_BITS]
                               :  w_acc_next[ACCUMULATOR_BITS-2 -: OUTPUT_BITS];
  assign w_pulse    = (w_acc_next[ACCUMULATOR_BITS-1 -: PULSEWIDTH_BITS] < pulse_width)
                      ? '1 : '0;
  assign w_noise    = w_lfsr_next[22 -: OUTPUT_BITS];

  always_comb begin
    w_mix = '1;
    w_any = 1'b0;
    if (en_saw)   begin w_mix = w_mix & w_saw;      w_any = 1'b1; end
    if (en_tri)   begin w_mix = w_mix & w_triangle; w_any = 1'b1; end
    if (en_pulse) begin w_mix = w_mix & w_pulse;    w_any = 1'b1; end
    if (en_noise) begin w_mix = w_mix & w_noise;    w_any = 1'b1; end
    if (!w_any) begin
      w_mix = '0;
    end
  end

  always_ff @(posedge main_clk) begin
    if (rst) begin
      r_acc            <= '0;
      r_sync_prev      <= 1'b0;
      r_lfsr           <= c_LFSR_SEED;
      r_noise_clk_prev <= 1'b0;
      r_dout           <= '0;
      r_dout_valid     <= 1'b0;
      r_msb            <= 1'b0;
    end else if (sample_tick) begin
      r_acc            <= w_acc_next;
      r_sync_prev      <= sync_source;
      r_lfsr           <= w_lfsr_next;
      r_noise_clk_prev <= w_noise_clk;
      r_dout           <= w_mix;
      r_dout_valid     <= 1'b1;
      r_msb            <= w_acc_next[ACCUMULATOR_BITS-1];
    end else begin
      r_dout_valid     <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign msb_out    = r_msb;

endmodule

`default_nettype wire

// File: tb/tb_tone_generator_multi.sv
// ============================================================================
// Module  : tb_tone_generator_multi
// Brief   : Scoreboard bench for tone_generator_multi (directed + ref model).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tone_generator_multi;

  localparam logic [22:0] c_SEED = 23'h7FFFF8;

  typedef struct {
    logic [11:0] d;
    logic        m;
  } exp_t;

  logic        main_clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic [15:0] tone_freq = 16'h0;
  logic [11:0] pulse_width = 12'h0;
  logic        en_saw = 1'b0, en_tri = 1'b0, en_pulse = 1'b0, en_noise = 1'b0;
  logic        test = 1'b0, en_sync = 1'b0, sync_source = 1'b0;
  logic        en_ringmod = 1'b0, ringmod_source = 1'b0;
  logic [11:0] dout;
  logic        dout_valid;
  logic        msb_out;

  int total = 0;
  int bad = 0;
  int ones_cnt = 0;
  exp_t q[$];

  // Reference model state
  logic [23:0] m_acc = '0;
  logic        m_sync_prev = 1'b0;
  logic [22:0] m_lfsr = c_SEED;
  logic        m_ncp = 1'b0;

  tone_generator_multi dut (
    .main_clk(main_clk), .rst(rst), .sample_tick(sample_tick),
    .tone_freq(tone_freq), .pulse_width(pulse_width),
    .en_saw(en_saw), .en_tri(en_tri), .en_pulse(en_pulse), .en_noise(en_noise),
    .test(test), .en_sync(en_sync), .sync_source(sync_source),
    .en_ringmod(en_ringmod), .ringmod_source(ringmod_source),
    .dout(dout), .dout_valid(dout_valid), .msb_out(msb_out)
  );

  always #5 main_clk = ~main_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_acc = '0; m_sync_prev = 1'b0; m_lfsr = c_SEED; m_ncp = 1'b0;
  endtask

  task automatic model_tick(output exp_t e);
    logic        nb, inv, any;
    logic [11:0] saw, trw, pul, noi, w;
    if (test) begin
      m_acc = '0;
      m_lfsr = c_SEED;
    end else if (en_sync && sync_source && !m_sync_prev) begin
      m_acc = '0;
    end else begin
      m_acc = m_acc + {8'h00, tone_freq};
    end
    m_sync_prev = sync_source;
    nb = m_acc[19];
    if (!test && nb && !m_ncp) begin
      if (m_lfsr == 23'd0) m_lfsr = c_SEED;
      else m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
    end
    m_ncp = nb;
    saw = m_acc[23:12];
    inv = en_ringmod ? (m_acc[23] ^ ringmod_source) : m_acc[23];
    trw = inv ? ~m_acc[22:11] : m_acc[22:11];
    pul = (m_acc[23:12] < pulse_width) ? 12'hFFF : 12'h000;
    noi = m_lfsr[22:11];
    w = 12'hFFF; any = 1'b0;
    if (en_saw)   begin w = w & saw; any = 1'b1; end
    if (en_tri)   begin w = w & trw; any = 1'b1; end
    if (en_pulse) begin w = w & pul; any = 1'b1; end
    if (en_noise) begin w = w & noi; any = 1'b1; end
    e.d = any ? w : 12'h000;
    e.m = m_acc[23];
  endtask

  task automatic do_reset();
    @(negedge main_clk);
    rst = 1'b1; sample_tick = 1'b0;
    @(negedge main_clk);
    rst = 1'b0;
    model_reset();
    @(negedge main_clk);
  endtask

  task automatic run_ticks(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge main_clk);
      sample_tick = 1'b1;
      model_tick(e);
      q.push_back(e);
    end
    @(negedge main_clk);
    sample_tick = 1'b0;
  endtask

  // Tick whose expectation is a hand-computed constant; model kept in step.
  task automatic hand_tick(input logic [11:0] d, input logic m, input int gap);
    exp_t e;
    @(negedge main_clk);
    sample_tick = 1'b1;
    model_tick(e);
    e.d = d; e.m = m;
    q.push_back(e);
    @(negedge main_clk);
    sample_tick = 1'b0;
    repeat (gap) @(negedge main_clk);
  endtask

  // Monitor: pops one expectation per valid output.
  always @(negedge main_clk) begin
    if (dout_valid === 1'b1) begin
      if (dout === 12'hFFF) ones_cnt++;
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: dout=%0h with no pending sample", dout);
      end else begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (dout !== e.d || msb_out !== e.m) begin
          bad++;
          $display("FAIL sample: dout=%0h msb=%0b expected dout=%0h msb=%0b", dout, msb_out, e.d, e.m);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge main_clk);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_valid", 32'(dout_valid), 32'h0);
    check("reset_msb", 32'(msb_out), 32'h0);
    rst = 1'b0;
    model_reset();

    // Sawtooth, spaced ticks: valid must be a single-cycle pulse each time
    tone_freq = 16'h8000; en_saw = 1'b1;
    hand_tick(12'h008, 1'b0, 2);
    hand_tick(12'h010, 1'b0, 2);
    hand_tick(12'h018, 1'b0, 2);
    hand_tick(12'h020, 1'b0, 2);

    // Hard sync
    do_reset();
    en_sync = 1'b1; sync_source = 1'b0;
    hand_tick(12'h008, 1'b0, 0);
    hand_tick(12'h010, 1'b0, 0);
    hand_tick(12'h018, 1'b0, 0);
    sync_source = 1'b1;
    hand_tick(12'h000, 1'b0, 0);
    hand_tick(12'h008, 1'b0, 0);
    sync_source = 1'b0;
    hand_tick(12'h010, 1'b0, 0);
    sync_source = 1'b1;
    hand_tick(12'h000, 1'b0, 1);
    en_sync = 1'b0; sync_source = 1'b0; en_saw = 1'b0;

    // Triangle, then ring-modulated triangle
    do_reset();
    en_tri = 1'b1; tone_freq = 16'hFFFF;
    run_ticks(600);
    do_reset();
    en_ringmod = 1'b1; ringmod_source = 1'b1;
    hand_tick(12'hFE0, 1'b0, 0);
    run_ticks(599);
    en_ringmod = 1'b0; ringmod_source = 1'b0; en_tri = 1'b0;

    // Pulse: 25% duty over one full accumulator period
    do_reset();
    en_pulse = 1'b1; pulse_width = 12'h400; tone_freq = 16'h4000;
    ones_cnt = 0;
    run_ticks(1024);
    @(negedge main_clk);
    check("pulse_duty_count", 32'(ones_cnt), 32'd256);
    pulse_width = 12'h000;
    run_ticks(64);
    en_pulse = 1'b0;

    // Noise: test holds seed, then long run against the model
    do_reset();
    en_noise = 1'b1; tone_freq = 16'hFFFF; test = 1'b1;
    hand_tick(12'hFFF, 1'b0, 0);
    hand_tick(12'hFFF, 1'b0, 0);
    hand_tick(12'hFFF, 1'b0, 0);
    test = 1'b0;
    run_ticks(16100);
    en_noise = 1'b0;

    // Saw AND triangle
    do_reset();
    en_saw = 1'b1; en_tri = 1'b1; tone_freq = 16'h3210;
    hand_tick(12'h002, 1'b0, 0);
    run_ticks(100);

    // Reset coinciding with a tick discards that sample
    @(negedge main_clk);
    rst = 1'b1; sample_tick = 1'b1;
    @(negedge main_clk);
    rst = 1'b0; sample_tick = 1'b0;
    model_reset();
    check("midreset_dout", 32'(dout), 32'h0);
    check("midreset_valid", 32'(dout_valid), 32'h0);
    check("midreset_msb", 32'(msb_out), 32'h0);
    run_ticks(20);

    repeat (3) @(negedge main_clk);
    check("queue_drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tone_generator_multi.md
Name: tone_generator_multi

Overview:
- Self-contained oscillator voice core, successor to the combinational triangle shaper.
- Owns its phase accumulator, advanced once per sample strobe.
- Produces triangle, sawtooth, pulse and LFSR noise waveforms, combined SID-style by bitwise AND, with hard sync and XOR ring modulation.
- Sits between the per-voice register file and the envelope/mixer stage; its accumulator MSB is exported for chaining sync/ringmod to the neighbouring voice.

Parameters:
- ACCUMULATOR_BITS, 24: phase accumulator width.
- FREQ_BITS, 16: tone frequency increment width (zero-extended into accumulator).
- PULSEWIDTH_BITS, 12: pulse width compare width (≤ ACCUMULATOR_BITS).
- OUTPUT_BITS, 12: output sample width (≤ ACCUMULATOR_BITS-1, ≤ 23).

Ports:
- main_clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle strobe; one sample step per strobe.
- tone_freq  in  FREQ_BITS  accumulator increment.
- pulse_width  in  PULSEWIDTH_BITS  pulse duty threshold.
- en_saw, en_tri, en_pulse, en_noise  in  1 each  waveform enables.
- test  in  1  holds accumulator at 0 and LFSR at seed.
- en_sync  in  1  hard sync enable.
- sync_source  in  1  neighbour accumulator MSB.
- en_ringmod  in  1  ring modulation enable.
- ringmod_source  in  1  neighbour accumulator MSB.
- dout  out  OUTPUT_BITS  registered waveform sample.
- dout_valid  out  1  high one cycle when dout updates.
- msb_out  out  1  accumulator MSB, registered.

Behaviour:
- Reset (synchronous, rst=1 at edge): acc=0, sync_prev=0, lfsr=23'h7FFFF8, noise_clk_prev=0, dout=0, dout_valid=0, msb_out=0. Reset overrides sample_tick on the same edge; a reset mid-stream discards the in-flight sample.
- Cycles without sample_tick: all state held; dout_valid=0.
- On sample_tick (cycle T), priority is:
  1. test=1: acc←0, lfsr←seed.
  2. Else if en_sync and sync_source=1 and sync_prev=0: acc←0. This is a rising edge judged tick-to-tick.
  3. Else acc←acc+tone_freq, modulo 2^ACCUMULATOR_BITS. Wrap is silent.
- sync_prev←sync_source on every tick regardless of en_sync.
- Noise LFSR: 23-bit Fibonacci, feedback = lfsr[22]^lfsr[17], shifted left with feedback into bit 0. It steps on a tick when new acc[ACCUMULATOR_BITS-5] is 1 and noise_clk_prev is 0. noise_clk_prev tracks that bit each tick. An all-zero LFSR is unreachable; if forced, it reloads the seed on the next step.
- Waveforms are computed from the NEW acc/lfsr values (post-update) and registered at T+1. Latency is one cycle: dout and dout_valid=1 appear in cycle T+1.
  - saw = acc[ACCUMULATOR_BITS-1 -: OUTPUT_BITS].
  - invert = en_ringmod ? (acc MSB ^ ringmod_source) : acc MSB.
  - tri = invert ? ~acc[ACCUMULATOR_BITS-2 -: OUTPUT_BITS] : acc[ACCUMULATOR_BITS-2 -: OUTPUT_BITS].
  - pulse = all ones if acc[ACCUMULATOR_BITS-1 -: PULSEWIDTH_BITS] < pulse_width, else 0. pulse_width=0 gives constant 0.
  - noise = lfsr[22 -: OUTPUT_BITS].
- dout = bitwise AND of all enabled waveforms. No enable set gives dout=0.
- msb_out = new acc MSB, updated with dout.
- Input changes between ticks take effect at the next tick only. Inputs are sampled on the tick edge.

Test Plan:
- Reset then tone_freq=16'h8000, en_saw=1, 4 ticks → dout 0x008, 0x010, 0x018, 0x020. Each appears one cycle after its tick with dout_valid high for exactly one cycle.
- en_tri=1, tone_freq=16'hFFFF, run 600 ticks → dout rises to 0xFFF and falls symmetrically; inverts at acc MSB toggle. Adding en_ringmod=1, ringmod_source=1 yields the inverted sequence, bit-exact ~tri.
- en_pulse=1, pulse_width=12'h400, sweep full period → dout=0xFFF for exactly 25% of ticks. pulse_width=0 → always 0.
- en_sync=1, sync_source 0→1 on tick N with acc≠0 → acc=0 and dout=0x000 (saw) at N+1. sync_source held high on N+1 → normal advance, no re-sync.
- en_noise=1, test=1 for 3 ticks then test=0 → LFSR reseeds to 0x7FFFF8. Output sequence matches the reference model for ≥1000 steps.
- rst asserted on the same edge as sample_tick mid-stream → all outputs 0, dout_valid=0 next cycle. en_saw+en_tri together → dout = saw & tri.
